// File: rtl/ctrl_pipe.sv
// Control-word pipeline: carries decoded control bits through STAGES stages with
// per-stage stall/flush, upstream hold propagation and a multi-cycle hold on stage 0.

module ctrl_pipe_stage #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          hold,
    input  logic          upHold,
    input  logic [CW-1:0] upCtrl,
    input  logic          upValid,
    output logic [CW-1:0] ctrl,
    output logic          valid
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl  <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            ctrl  <= '0;
            valid <= 1'b0;
        end else if (!hold) begin
            // upstream stuck while we advance: a bubble fills the gap
            if (upHold) begin
                ctrl  <= '0;
                valid <= 1'b0;
            end else begin
                ctrl  <= upCtrl;
                valid <= upValid;
            end
        end
    end
endmodule

module ctrl_pipe #(
    parameter int CW        = 16,
    parameter int STAGES    = 3,
    parameter int MC_CYCLES = 4,
    parameter int CNTW      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CW-1:0]        ctrlD,
    input  logic                 validD,
    input  logic                 mcD,
    input  logic [STAGES-1:0]    stall,
    input  logic [STAGES-1:0]    flush,
    output logic [STAGES*CW-1:0] ctrl_q,
    output logic [STAGES-1:0]    valid_q,
    output logic                 stallD,
    output logic                 mc_busy,
    output logic [CNTW-1:0]      mc_cnt
);
    logic [STAGES-1:0]         hold;
    logic [STAGES-1:0]         upHold;
    logic [STAGES-1:0]         upValid;
    logic [STAGES-1:0][CW-1:0] upCtrl;
    logic [STAGES-1:0][CW-1:0] stageCtrl;
    logic                      load0;

    assign mc_busy = |mc_cnt;
    assign stallD  = hold[0];
    assign ctrl_q  = stageCtrl;
    assign load0   = !flush[0] && !hold[0];

    // hold resolves from the last stage back towards decode
    always_comb begin
        hold = '0;
        hold[STAGES-1] = stall[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--)
            hold[k] = stall[k] | hold[k+1];
        hold[0] = hold[0] | mc_busy;
    end

    always_comb begin
        upHold     = '0;
        upCtrl     = '0;
        upValid    = '0;
        upCtrl[0]  = ctrlD;
        upValid[0] = validD;
        for (int k = 1; k < STAGES; k++) begin
            upHold[k]  = hold[k-1];
            upCtrl[k]  = stageCtrl[k-1];
            upValid[k] = valid_q[k-1];
        end
    end

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : gStage
            ctrl_pipe_stage #(.CW(CW)) uStage (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush[k]),
                .hold   (hold[k]),
                .upHold (upHold[k]),
                .upCtrl (upCtrl[k]),
                .upValid(upValid[k]),
                .ctrl   (stageCtrl[k]),
                .valid  (valid_q[k])
            );
        end
    endgenerate

    // counter counts the extra cycles beyond the load edge; downstream stalls don't pause it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mc_cnt <= '0;
        else if (flush[0])
            mc_cnt <= '0;
        else if (MC_CYCLES > 1 && load0 && validD && mcD)
            mc_cnt <= CNTW'(MC_CYCLES - 1);
        else if (mc_busy)
            mc_cnt <= mc_cnt - CNTW'(1);
    end
endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: directed scenarios then random traffic,
// checked against a timestamp-based reference model.

module tb_ctrl_pipe;
    localparam int CW = 16, S = 3, MC = 4, CNTW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [CW-1:0]   ctrlD;
    logic            validD, mcD;
    logic [S-1:0]    stall, flush;
    logic [S*CW-1:0] ctrl_q;
    logic [S-1:0]    valid_q;
    logic            stallD, mc_busy;
    logic [CNTW-1:0] mc_cnt;

    ctrl_pipe #(.CW(CW), .STAGES(S), .MC_CYCLES(MC), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .ctrlD(ctrlD), .validD(validD), .mcD(mcD),
        .stall(stall), .flush(flush), .ctrl_q(ctrl_q), .valid_q(valid_q),
        .stallD(stallD), .mc_busy(mc_busy), .mc_cnt(mc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [S-1:0][CW-1:0] ctrl;
        logic [S-1:0]         val;
        int                   cnt;
        logic                 sd;
    } exp_t;

    exp_t sbq[$];
    int checks = 0, errors = 0;

    logic [CW-1:0] mCtrl[S];
    logic          mVal[S];
    int            mcEnd = 0, cyc = 0;
    logic          lastSd = 1'b0;
    logic          sdSample;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < S; k++) begin
            mCtrl[k] = '0;
            mVal[k]  = 1'b0;
        end
        mcEnd  = cyc;
        lastSd = 1'b0;
    endtask

    // Drive one cycle of inputs and predict the cycle's stallD plus the post-edge state.
    task automatic step(input logic [CW-1:0] c, input logic v, input logic m,
                        input logic [S-1:0] st, input logic [S-1:0] fl);
        exp_t          e;
        logic          h[S];
        int            rem;
        logic [CW-1:0] nC[S];
        logic          nV[S];
        @(negedge clk);
        ctrlD = c; validD = v; mcD = m; stall = st; flush = fl;
        rem = (mcEnd > cyc) ? mcEnd - cyc : 0;
        for (int k = 0; k < S; k++) begin
            h[k] = 1'b0;
            for (int j = k; j < S; j++) if (st[j]) h[k] = 1'b1;
        end
        if (rem != 0) h[0] = 1'b1;
        e.sd = h[0];
        for (int k = 0; k < S; k++) begin
            if (fl[k])                begin nC[k] = '0;         nV[k] = 1'b0;       end
            else if (h[k])            begin nC[k] = mCtrl[k];   nV[k] = mVal[k];    end
            else if (k > 0 && h[k-1]) begin nC[k] = '0;         nV[k] = 1'b0;       end
            else if (k == 0)          begin nC[k] = c;          nV[k] = v;          end
            else                      begin nC[k] = mCtrl[k-1]; nV[k] = mVal[k-1];  end
        end
        if (fl[0]) mcEnd = cyc + 1;
        else if (!h[0] && v && m && MC > 1) mcEnd = cyc + MC;
        cyc++;
        for (int k = 0; k < S; k++) begin
            mCtrl[k] = nC[k];
            mVal[k]  = nV[k];
            e.ctrl[k] = nC[k];
            e.val[k]  = nV[k];
        end
        e.cnt = (mcEnd > cyc) ? mcEnd - cyc : 0;
        lastSd = e.sd;
        sbq.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 1'b0, 1'b0, '0, '0);
    endtask

    // monitor: stallD is sampled mid-cycle, registered outputs just after the edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2 sdSample = stallD;
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("ctrl_q",  64'(ctrl_q),  64'(e.ctrl));
                chk("valid_q", 64'(valid_q), 64'(e.val));
                chk("mc_cnt",  64'(mc_cnt),  64'(e.cnt));
                chk("mc_busy", 64'(mc_busy), 64'(e.cnt != 0));
                chk("stallD",  64'(sdSample), 64'(e.sd));
            end
        end
    end

    initial begin
        logic [CW-1:0] c;
        logic          v, m;
        logic [S-1:0]  st, fl;
        rst = 1'b0; ctrlD = '0; validD = 1'b0; mcD = 1'b0; stall = '0; flush = '0;
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctrl_q",  64'(ctrl_q),  64'd0);
        chk("rst_valid_q", 64'(valid_q), 64'd0);
        chk("rst_mc_cnt",  64'(mc_cnt),  64'd0);
        chk("rst_stallD",  64'(stallD),  64'd0);
        @(negedge clk);
        rst = 1'b1;

        // basic latency
        step(16'h00A5, 1'b1, 1'b0, '0, '0);
        idle(3);
        // stall[1] for two cycles with A in stage 1
        step(16'h0011, 1'b1, 1'b0, '0, '0);
        step(16'h0022, 1'b1, 1'b0, '0, '0);
        step(16'h0033, 1'b1, 1'b0, 3'b010, '0);
        step(16'h0033, 1'b1, 1'b0, 3'b010, '0);
        step(16'h0033, 1'b1, 1'b0, '0, '0);
        idle(3);
        // flush beats stall on stage 0
        step(16'h0044, 1'b1, 1'b0, '0, '0);
        step('0, 1'b0, 1'b0, 3'b001, 3'b001);
        idle(2);
        // multi-cycle op occupies stage 0
        step(16'h0055, 1'b1, 1'b1, '0, '0);
        repeat (4) step(16'h0066, 1'b1, 1'b0, '0, '0);
        idle(3);
        // flush[0] cancels an in-flight multi-cycle hold
        step(16'h0077, 1'b1, 1'b1, '0, '0);
        step(16'h0088, 1'b1, 1'b0, '0, '0);
        step(16'h0088, 1'b1, 1'b0, '0, 3'b001);
        step(16'h0088, 1'b1, 1'b0, '0, '0);
        idle(3);
        // asynchronous reset mid-stream with mc_cnt=2 and all stages valid
        step(16'h00A1, 1'b1, 1'b0, '0, '0);
        step(16'h00A2, 1'b1, 1'b0, '0, '0);
        step(16'h00A3, 1'b1, 1'b1, '0, '0);
        step(16'h00A4, 1'b1, 1'b0, 3'b100, '0);
        @(negedge clk);
        ctrlD = '0; validD = 1'b0; mcD = 1'b0; stall = '0; flush = '0;
        #3 rst = 1'b0;
        #1;
        chk("arst_ctrl_q",  64'(ctrl_q),  64'd0);
        chk("arst_valid_q", 64'(valid_q), 64'd0);
        chk("arst_mc_cnt",  64'(mc_cnt),  64'd0);
        chk("arst_mc_busy", 64'(mc_busy), 64'd0);
        chk("arst_stallD",  64'(stallD),  64'd0);
        modelReset();
        @(negedge clk);
        rst = 1'b1;
        step(16'h00B1, 1'b1, 1'b0, '0, '0);
        idle(3);

        // random traffic; decode re-presents its word while stalled
        c = '0; v = 1'b0; m = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!lastSd) begin
                c = CW'($urandom);
                v = ($urandom_range(0, 3) != 0);
                m = ($urandom_range(0, 6) == 0);
            end
            for (int k = 0; k < S; k++) begin
                st[k] = ($urandom_range(0, 5) == 0);
                fl[k] = ($urandom_range(0, 11) == 0);
            end
            step(c, v, m, st, fl);
        end
        idle(2);
        repeat (3) @(negedge clk);
        chk("sb_drain", 64'(sbq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
